// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: a free-running 3-bit program counter that indexes
// a fixed 8 x 16-bit instruction ROM.
//
// Interface contract
//   - The block has no handshake. pc advances once per rising clk edge while
//     reset is high and wraps from 7 to 0 without any flag.
//   - instruction is a purely combinational read of ROM[pc]. It is valid in
//     the same cycle as pc, once combinational settling completes.
//   - reset is asynchronous and active-low. Asserting it forces pc to 0 at
//     once. It also wins over any clock edge that arrives while it is low.
module instruction_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  pc,
  output logic [15:0] instruction
);

  logic [2:0]  pc_q;
  logic [2:0]  pc_d;
  logic [15:0] rom_data;

  // Next program counter: unconditional increment, wrapping modulo 8.
  always_comb begin
    pc_d = pc_q + 3'd1;
  end

  // Program counter register, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 3'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Fixed instruction ROM, read combinationally at the current pc.
  always_comb begin
    rom_data = 16'h1001;
    case (pc_q)
      3'd0: rom_data = 16'h1001;
      3'd1: rom_data = 16'h2202;
      3'd2: rom_data = 16'h3403;
      3'd3: rom_data = 16'h4604;
      3'd4: rom_data = 16'h5805;
      3'd5: rom_data = 16'h6A06;
      3'd6: rom_data = 16'h7C07;
      3'd7: rom_data = 16'h8E08;
      default: rom_data = 16'h1001;
    endcase
  end

  assign pc          = pc_q;
  assign instruction = rom_data;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage.
// A behavioural model tracks the expected pc from clock and reset events.
// The ROM contents are derived arithmetically from the word index. One
// compare process checks the DUT against that model on every falling edge.
// Directed checks against hand-written literals pin the model itself.
module tb_instruction_fetch_stage;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [2:0]  pc;
  logic [15:0] instruction;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  instruction_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Hand-written ROM image, used only by the directed checks.
  logic [15:0] lit_rom [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected pc: clears whenever reset is low, otherwise counts edges mod 8.
  int m_pc = 0;

  // Word i of the ROM reads as digits (i+1), 2i, 0, (i+1).
  function automatic logic [15:0] rom_model(input int i);
    logic [3:0] a;
    logic [3:0] b;
    a = 4'(i + 1);
    b = 4'(2 * i);
    return {a, b, 4'h0, a};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_pc = 0;
    else        m_pc = (m_pc + 1) % 8;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",    {13'd0, pc}, 16'(m_pc));
      chk("model_instr", instruction, rom_model(m_pc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic edge_then_check(input string name, input int exp_pc);
    @(posedge clk);
    #1;
    chk({name, "_pc"},    {13'd0, pc}, 16'(exp_pc));
    chk({name, "_instr"}, instruction, lit_rom[exp_pc]);
  endtask

  // Change reset between edges, a couple of ns after the falling edge.
  task automatic drive_reset_midcycle(input logic val);
    @(negedge clk);
    #2;
    reset = val;
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    lit_rom[0] = 16'h1001; lit_rom[1] = 16'h2202;
    lit_rom[2] = 16'h3403; lit_rom[3] = 16'h4604;
    lit_rom[4] = 16'h5805; lit_rom[5] = 16'h6A06;
    lit_rom[6] = 16'h7C07; lit_rom[7] = 16'h8E08;

    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    // Async reset, before any clock edge.
    chk("pre_edge_pc",    {13'd0, pc}, 16'd0);
    chk("pre_edge_instr", instruction, 16'h1001);
    cmp_en = 1'b1;

    // Hold reset low across two edges.
    edge_then_check("hold_rst_e1", 0);
    edge_then_check("hold_rst_e2", 0);

    // Release mid-cycle: pc stays 0 until the next rising edge.
    drive_reset_midcycle(1'b1);
    chk("release_pc", {13'd0, pc}, 16'd0);

    // Seven edges step pc through 1..7.
    for (int k = 1; k <= 7; k++) edge_then_check("step", k);

    // Wrap-around on the 8th and 9th edges.
    edge_then_check("wrap8", 0);
    edge_then_check("wrap9", 1);

    // Advance to pc = 5.
    for (int k = 2; k <= 5; k++) edge_then_check("to5", k);

    // Mid-cycle reset at pc = 5 takes effect at once.
    drive_reset_midcycle(1'b0);
    chk("midrst_pc",    {13'd0, pc}, 16'd0);
    chk("midrst_instr", instruction, 16'h1001);
    edge_then_check("midrst_hold1", 0);
    edge_then_check("midrst_hold2", 0);

    // Deassert mid-cycle, then the first edge gives pc = 1.
    drive_reset_midcycle(1'b1);
    chk("deassert_pc",    {13'd0, pc}, 16'd0);
    chk("deassert_instr", instruction, 16'h1001);
    edge_then_check("deassert_first", 1);

    // Free run for 200 ns: pc must step by one mod 8 each edge with no X/Z.
    begin
      int exp_pc;
      exp_pc = 1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        exp_pc = (exp_pc + 1) % 8;
        chk("run_pc",    {13'd0, pc}, 16'(exp_pc));
        chk("run_instr", instruction, lit_rom[exp_pc]);
        checks++;
        if ($isunknown({pc, instruction})) begin
          errors++;
          $display("FAIL run_xz: got pc=%b instr=%b expected known values", pc, instruction);
        end
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
